// File: rtl/muldiv_pkg.sv
// Shared types and sizing for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

  localparam int MULDIV_WIDTH = 32;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int MULDIV_CNT_W = cnt_width(MULDIV_WIDTH);

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract the
// divisor if it fits and report the resulting quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] partial;
  logic [WIDTH:0] diff;

  assign partial = {rem_in, dividend_bit};
  assign diff    = partial - {1'b0, divisor};
  assign q_bit   = (partial >= {1'b0, divisor});
  // The remainder always stays below the divisor, so it fits back into WIDTH bits.
  assign rem_out = q_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Works on magnitudes for WIDTH cycles, then applies sign correction in a single FIX cycle.
module mult_div_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH == MULDIV_WIDTH) ? MULDIV_CNT_W : cnt_width(WIDTH);

  muldiv_state_t      state, next_state;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operand_reg;
  logic [CNT_W-1:0]   cnt;
  logic               is_div, neg_main, neg_rem, div_zero;

  logic               op_arith, op_div, op_signed;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, div_next, product;
  logic [WIDTH-1:0]   div_rem, quotient, remainder, fix_hi, fix_lo;
  logic               div_q;

  assign op_arith  = (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  assign op_div    = (op == DIV) || (op == DIVU);
  assign op_signed = (op == MULT) || (op == DIV);
  assign abs_a     = (op_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
  assign abs_b     = (op_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;

  // Multiply: the multiplier sits in the low half and is consumed LSB-first while the
  // partial product grows in from the top.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand_reg} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in       (acc[2*WIDTH-1:WIDTH]),
    .dividend_bit (acc[WIDTH-1]),
    .divisor      (operand_reg),
    .rem_out      (div_rem),
    .q_bit        (div_q)
  );
  assign div_next = {div_rem, acc[WIDTH-2:0], div_q};

  // Divide by zero falls out of the restoring loop as remainder = |dividend|;
  // only the quotient needs forcing so the signed case matches the unsigned one.
  assign product   = neg_main ? -acc : acc;
  assign quotient  = acc[WIDTH-1:0];
  assign remainder = acc[2*WIDTH-1:WIDTH];
  always_comb begin
    fix_hi = product[2*WIDTH-1:WIDTH];
    fix_lo = product[WIDTH-1:0];
    if (is_div) begin
      fix_hi = neg_rem ? -remainder : remainder;
      fix_lo = div_zero ? '1 : (neg_main ? -quotient : quotient);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (start && !flush && op_arith) next_state = CALC;
      CALC:    if (flush) next_state = IDLE;
               else if (cnt == CNT_W'(WIDTH - 1)) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc         <= '0;
      operand_reg <= '0;
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_main    <= 1'b0;
      neg_rem     <= 1'b0;
      div_zero    <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (next_state == CALC) begin
            is_div      <= op_div;
            neg_main    <= op_signed && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
            neg_rem     <= op_signed && operand_a[WIDTH-1];
            div_zero    <= (operand_b == '0);
            operand_reg <= op_div ? abs_b : abs_a;
            acc         <= {{WIDTH{1'b0}}, (op_div ? abs_a : abs_b)};
            cnt         <= '0;
          end else if (start && !flush && op == MTHI) begin
            hi <= operand_a;
          end else if (start && !flush && op == MTLO) begin
            lo <= operand_a;
          end
        end
        CALC: begin
          if (!flush) begin
            acc <= is_div ? div_next : mul_next;
            cnt <= cnt + CNT_W'(1);
          end
        end
        FIX: begin
          if (!flush) begin
            hi   <= fix_hi;
            lo   <= fix_lo;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random ops
// compared against a plain-arithmetic HI/LO reference model.
module tb_mult_div_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  muldiv_op_t   op = MULT;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int           vectors = 0;
  int           miscompares = 0;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // MIPS HI/LO semantics from 64-bit arithmetic; SV division truncates toward zero
  // and the remainder follows the dividend, as MIPS requires.
  function automatic void refModel(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] rh, output logic [31:0] rl);
    int          ia, ib;
    longint      sa, sb, q, r;
    logic [63:0] p;
    ia = a;
    ib = b;
    sa = ia;
    sb = ib;
    rh = '0;
    rl = '0;
    case (o)
      MULTU: begin p = {32'd0, a} * {32'd0, b}; rh = p[63:32]; rl = p[31:0]; end
      MULT:  begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
      DIVU: begin
        if (b == 0) begin rh = a; rl = 32'hFFFF_FFFF; end
        else begin rh = a % b; rl = a / b; end
      end
      DIV: begin
        if (b == 0) begin rh = a; rl = 32'hFFFF_FFFF; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin rh = '0; rl = 32'h8000_0000; end
        else begin q = sa / sb; r = sa % sb; rh = r[31:0]; rl = q[31:0]; end
      end
      default: ;
    endcase
  endfunction

  // Presents one request for exactly one rising edge and returns #1 after that edge.
  task automatic applyStimulus(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    start = 1'b1;
    op = o;
    operand_a = a;
    operand_b = b;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic runArith(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b, input int intrude_at);
    int          edges = 0;
    int          busy_cycles = 0;
    bit          held = 1'b1;
    logic [31:0] eh, el;
    refModel(o, a, b, eh, el);
    applyStimulus(o, a, b);
    while (done !== 1'b1 && edges < 100) begin
      if (busy === 1'b1) busy_cycles++;
      if (hi !== model_hi || lo !== model_lo) held = 1'b0;
      start = (edges == intrude_at);
      if (edges == intrude_at) begin
        op = MULT;
        operand_a = 32'h0000_1234;
        operand_b = 32'h0000_0777;
      end
      @(posedge clock);
      #1;
      edges++;
    end
    start = 1'b0;
    checkOutput({o.name(), "_no_timeout"}, 64'(edges < 100), 64'd1);
    checkOutput({o.name(), "_latency"}, 64'(edges), 64'(W + 1));
    checkOutput({o.name(), "_busy_cycles"}, 64'(busy_cycles), 64'(W + 1));
    checkOutput({o.name(), "_hilo_held"}, 64'(held), 64'd1);
    checkOutput({o.name(), "_busy_at_done"}, 64'(busy), 64'd0);
    checkOutput({o.name(), "_hi"}, 64'(hi), 64'(eh));
    checkOutput({o.name(), "_lo"}, 64'(lo), 64'(el));
    model_hi = eh;
    model_lo = el;
  endtask

  task automatic runMove(input muldiv_op_t o, input logic [31:0] a);
    applyStimulus(o, a, 32'h0);
    if (o == MTHI) model_hi = a;
    else model_lo = a;
    checkOutput({o.name(), "_hi"}, 64'(hi), 64'(model_hi));
    checkOutput({o.name(), "_lo"}, 64'(lo), 64'(model_lo));
    checkOutput({o.name(), "_busy"}, 64'(busy), 64'd0);
    checkOutput({o.name(), "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] ra, rb;
    int          sel;
    bit          saw_done;
    bit          held;

    repeat (2) @(negedge clock);
    checkOutput("reset_hi", 64'(hi), 64'd0);
    checkOutput("reset_lo", 64'(lo), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    reset = 1'b1;

    runArith(MULTU, 32'hFFFF_FFFF, 32'd2, -1);
    @(posedge clock);
    #1;
    checkOutput("done_single_pulse", 64'(done), 64'd0);
    runArith(MULT, 32'hFFFF_FFFD, 32'd5, -1);
    runArith(DIV, 32'hFFFF_FFF9, 32'd2, -1);
    runArith(DIVU, 32'd7, 32'd0, -1);
    runArith(DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    runArith(DIV, 32'hFFFF_FFF9, 32'd0, -1);
    runMove(MTHI, 32'h1234_5678);
    runMove(MTLO, 32'h9ABC_DEF0);
    runArith(MULT, 32'hFFFF_0003, 32'h0001_0005, 5);

    // Undefined opcode and flush-while-idle must both leave the unit untouched.
    applyStimulus(muldiv_op_t'(3'd6), 32'hDEAD_BEEF, 32'd3);
    checkOutput("undef_op_busy", 64'(busy), 64'd0);
    checkOutput("undef_op_hilo", {hi, lo}, {model_hi, model_lo});
    flush = 1'b1;
    applyStimulus(MULTU, 32'd3, 32'd3);
    flush = 1'b0;
    checkOutput("flush_beats_start", 64'(busy), 64'd0);

    // Flush at cycle 10 of a MULTU.
    applyStimulus(MULTU, 32'd6, 32'd7);
    repeat (9) begin
      @(posedge clock);
      #1;
    end
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    checkOutput("flush_busy_drop", 64'(busy), 64'd0);
    saw_done = 1'b0;
    held = 1'b1;
    repeat (40) begin
      if (done === 1'b1) saw_done = 1'b1;
      if (hi !== model_hi || lo !== model_lo) held = 1'b0;
      @(posedge clock);
      #1;
    end
    checkOutput("flush_no_done", 64'(saw_done), 64'd0);
    checkOutput("flush_hilo_held", 64'(held), 64'd1);
    runArith(MULTU, 32'd6, 32'd7, -1);

    // Asynchronous reset in the middle of a divide.
    applyStimulus(DIV, 32'h7654_3210, 32'd13);
    repeat (15) begin
      @(posedge clock);
      #1;
    end
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midop_reset_hi", 64'(hi), 64'd0);
    checkOutput("midop_reset_lo", 64'(lo), 64'd0);
    checkOutput("midop_reset_busy", 64'(busy), 64'd0);
    checkOutput("midop_reset_done", 64'(done), 64'd0);
    model_hi = '0;
    model_lo = '0;
    @(negedge clock);
    reset = 1'b1;
    runArith(DIVU, 32'd100, 32'd7, -1);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 15);
        2: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      if (sel < 8) runArith(muldiv_op_t'(3'(sel % 4)), ra, rb, -1);
      else runMove(sel == 8 ? MTHI : MTLO, ra);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
